// File: rtl/serial_encoder_pkg.sv
// rtl/serial_encoder_pkg.sv - shared state encoding and popcount helper for the serial one-hot encoder
package serial_encoder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Widest vector the helper accepts; callers zero-extend narrower vectors.
    localparam int MAX_W = 256;

    function automatic logic popcount_le1(input logic [MAX_W-1:0] v);
        return (v & (v - MAX_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/lowest_set_index.sv
// rtl/lowest_set_index.sv - combinational priority encoder, lowest set index wins
module lowest_set_index #(
    parameter int N = 3
) (
    input  logic [0:(2**N)-1] vec,
    output logic [N-1:0]      idx,
    output logic              any_set
);

    localparam int W = 2**N;

    // Scan high to low so the last assignment is the lowest set bit.
    always_comb begin
        idx = '0;
        for (int i = W-1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[N-1:0];
            end
        end
    end

    assign any_set = |vec;

endmodule

// File: rtl/serial_onehot_encoder.sv
// rtl/serial_onehot_encoder.sv - captures a multi-hot vector and streams the index of each set bit, lowest first
module serial_onehot_encoder
    import serial_encoder_pkg::*;
#(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:(2**N)-1] d,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_idx,
    output logic              out_last,
    output logic              out_zero
);

    localparam int W = 2**N;

    state_t         state;
    logic [0:W-1]   pending;
    logic           zflag;
    logic [N-1:0]   low_idx;
    logic           any_set;

    lowest_set_index #(
        .N (N)
    ) u_lowest_set_index (
        .vec     (pending),
        .idx     (low_idx),
        .any_set (any_set)
    );

    // Outputs depend only on registered state so no input reaches an output combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign out_idx   = (out_valid && any_set) ? low_idx : '0;
    assign out_last  = out_valid && popcount_le1({{(MAX_W-W){1'b0}}, pending});
    assign out_zero  = out_valid && zflag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pending <= '0;
            zflag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pending <= d;
                        zflag   <= (d == '0);
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        pending[out_idx] <= 1'b0;
                        if (out_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_onehot_encoder.sv
// tb/tb_serial_onehot_encoder.sv - directed self-checking bench for serial_onehot_encoder
module tb_serial_onehot_encoder;

    localparam int N = 3;
    localparam int W = 2**N;

    logic           clk;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    logic [0:W-1]   d;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_idx;
    logic           out_last;
    logic           out_zero;

    int tests_run;
    int tests_failed;

    serial_onehot_encoder #(
        .N (N)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mask bit i becomes d[i], independent of the vector's ascending declaration
    function automatic logic [0:W-1] mk(input logic [W-1:0] mask);
        logic [0:W-1] r;
        for (int i = 0; i < W; i++) r[i] = mask[i];
        return r;
    endfunction

    task automatic check_beat(input string tag, input int idx, input logic last, input logic zero);
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".ready"}, in_ready, 0);
        check({tag, ".idx"},   out_idx, idx);
        check({tag, ".last"},  out_last, last);
        check({tag, ".zero"},  out_zero, zero);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".in_ready"},  in_ready, 1);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".out_idx"},   out_idx, 0);
        check({tag, ".out_last"},  out_last, 0);
        check({tag, ".out_zero"},  out_zero, 0);
    endtask

    // Presents vec for exactly one accepting edge; returns at the negedge of the first beat.
    task automatic send(input logic [0:W-1] vec);
        d        = vec;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        d         = '0;
        out_ready = 1'b0;

        // reset held for 3 cycles, then 5 idle cycles
        repeat (3) @(negedge clk);
        check_idle("rst");
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle%0d", i));
        end

        // bits {1,4,6}
        out_ready = 1'b1;
        send(mk(8'b0101_0010));
        check_beat("b146_0", 1, 0, 0);
        @(negedge clk);
        check_beat("b146_1", 4, 0, 0);
        @(negedge clk);
        check_beat("b146_2", 6, 1, 0);
        @(negedge clk);
        check_idle("b146_done");

        // all zeros: one marker beat
        send('0);
        check_beat("zero", 0, 1, 1);
        @(negedge clk);
        check_idle("zero_done");

        // all ones with out_ready alternating
        out_ready = 1'b0;
        send('1);
        for (int i = 0; i < W; i++) begin
            check_beat($sformatf("ones%0d", i), i, (i == W-1), 0);
            @(negedge clk);
            check_beat($sformatf("ones%0d_stall", i), i, (i == W-1), 0);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check_idle("ones_done");

        // {2,5} captured, then d={0} with in_valid held high through EMIT
        out_ready = 1'b1;
        d         = mk(8'b0010_0100);
        in_valid  = 1'b1;
        @(negedge clk);
        d = mk(8'b0000_0001);
        check_beat("hold_2", 2, 0, 0);
        @(negedge clk);
        check_beat("hold_5", 5, 1, 0);
        @(negedge clk);
        check_idle("hold_gap");
        @(negedge clk);
        in_valid = 1'b0;
        check_beat("hold_0", 0, 1, 0);
        @(negedge clk);
        check_idle("hold_done");

        // {3,7} captured, reset after the idx 3 beat
        send(mk(8'b1000_1000));
        check_beat("rstmid_3", 3, 0, 0);
        @(negedge clk);
        check_beat("rstmid_7pres", 7, 1, 0);
        reset_n = 1'b0;
        #1;
        check("rstmid.async_valid", out_valid, 0);
        check("rstmid.async_ready", in_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("rstmid_idle%0d", i));
        end

        // highest index alone
        send(mk(8'b1000_0000));
        check_beat("top7", 7, 1, 0);
        @(negedge clk);
        check_idle("top7_done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
